// File: rtl/minmax_pkg.sv
// minmax_pkg: shared trigger-mode enum and signed sentinel helpers for the envelope trigger
package minmax_pkg;
  typedef enum logic [1:0] {
    TRIG_FALL = 2'd0,
    TRIG_RISE = 2'd1,
    TRIG_BOTH = 2'd2
  } trigger_mode_t;
  function automatic longint signed_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint signed_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/window_extrema.sv
// window_extrema: per-window running min/max of accepted samples with registered peak-to-peak at close
module window_extrema
  import minmax_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axiiv,
  input  logic [DATA_WIDTH-1:0] axiid,
  input  logic                  window_restart,
  output logic                  close,
  output logic [DATA_WIDTH:0]   close_pp,
  output logic                  pp_valid,
  output logic [DATA_WIDTH:0]   pp
);
  localparam int CW = $clog2(WINDOW);
  localparam logic signed [DATA_WIDTH-1:0] MAX_S = DATA_WIDTH'(signed_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] MIN_S = DATA_WIDTH'(signed_min(DATA_WIDTH));
  logic [CW-1:0] count;
  logic signed [DATA_WIDTH-1:0] sample, run_min, run_max, next_min, next_max;
  always_comb begin
    sample   = $signed(axiid);
    next_min = (axiiv && sample < run_min) ? sample : run_min;
    next_max = (axiiv && sample > run_max) ? sample : run_max;
    close    = axiiv && !window_restart && count == CW'(WINDOW - 1);
    close_pp = {next_max[DATA_WIDTH-1], next_max} - {next_min[DATA_WIDTH-1], next_min};
  end
  // restart and close both reopen the window with sentinels so the next sample always lands
  always_ff @(posedge clk)
    if (rst || window_restart || close) begin
      count   <= '0;
      run_min <= MAX_S;
      run_max <= MIN_S;
    end else if (axiiv) begin
      count   <= count + 1'b1;
      run_min <= next_min;
      run_max <= next_max;
    end
  always_ff @(posedge clk)
    if (rst) begin
      pp_valid <= 1'b0;
      pp       <= '0;
    end else begin
      pp_valid <= close;
      if (close) pp <= close_pp;
    end
endmodule

// File: rtl/minmax_envelope_trigger.sv
// minmax_envelope_trigger: windowed peak-to-peak envelope with hysteresis state and edge trigger pulse.
// Define MINMAX_DEBOUNCE_EN to require DEBOUNCE_WINDOWS consecutive disagreeing closes per state change.
module minmax_envelope_trigger
  import minmax_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int WINDOW           = 500,
  parameter int TRIGGER_MODE     = 0,
  parameter int DEBOUNCE_WINDOWS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axiiv,
  input  logic [DATA_WIDTH-1:0] axiid,
  input  logic                  window_restart,
  input  logic [DATA_WIDTH:0]   low_threshold,
  input  logic [DATA_WIDTH:0]   high_threshold,
  output logic                  pp_valid,
  output logic [DATA_WIDTH:0]   pp,
  output logic                  active,
  output logic                  triggered
);
  localparam trigger_mode_t MODE = trigger_mode_t'(TRIGGER_MODE);
  logic close, req, differ, flip, trig;
  logic [DATA_WIDTH:0] close_pp;
  window_extrema #(.DATA_WIDTH(DATA_WIDTH), .WINDOW(WINDOW)) u_extrema (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .window_restart(window_restart),
    .close(close), .close_pp(close_pp), .pp_valid(pp_valid), .pp(pp)
  );
  always_comb begin
    req    = (close_pp < low_threshold) ? 1'b0 : (close_pp > high_threshold) ? 1'b1 : active;
    differ = close && req != active;
  end
`ifdef MINMAX_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_WINDOWS + 1);
  logic [DBW-1:0] deb, deb_inc;
  always_comb begin
    deb_inc = deb + 1'b1;
    flip    = differ && deb_inc == DBW'(DEBOUNCE_WINDOWS);
  end
  always_ff @(posedge clk)
    if (rst) deb <= '0;
    else if (close) deb <= (differ && !flip) ? deb_inc : '0;
`else
  assign flip = differ && DEBOUNCE_WINDOWS >= 1;
`endif
  assign trig = (MODE == TRIG_RISE) ? flip && !active :
                (MODE == TRIG_FALL) ? flip && active : flip;
  always_ff @(posedge clk)
    if (rst) begin
      active    <= 1'b0;
      triggered <= 1'b0;
    end else begin
      active    <= active ^ flip;
      triggered <= trig;
    end
endmodule
